// File: rtl/logic_engine_responder.sv
// Logic-engine responder: fetches a length-prefixed certificate descriptor from a
// registered word RAM and returns its rotate-XOR digest with a one-cycle ack.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | waiting for logic_req
// ADDR_ERR    | bad request address, one settle cycle before reporting
// ISSUE_LEN   | reading the length word at base
// CAPTURE_LEN | length word on mem_rdata, issue first payload read
// STREAM      | folding one payload word per cycle
// DELAY       | LAT_EXTRA idle cycles before ack
// ACK         | one-cycle logic_ack pulse
// WAIT_LOW    | waiting for the CPU to release logic_req
module logic_engine_responder #(
    parameter int ADDR_W    = 8,
    parameter int MAX_LEN   = 64,
    parameter int LAT_EXTRA = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              logic_req,
    input  logic [31:0]       logic_addr,
    output logic              logic_ack,
    output logic [31:0]       logic_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              err,
    output logic [31:0]       req_count
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_ISSUE_LEN   = 3'd1;
    localparam logic [2:0] S_CAPTURE_LEN = 3'd2;
    localparam logic [2:0] S_STREAM      = 3'd3;
    localparam logic [2:0] S_DELAY       = 3'd4;
    localparam logic [2:0] S_ACK         = 3'd5;
    localparam logic [2:0] S_WAIT_LOW    = 3'd6;
    localparam logic [2:0] S_ADDR_ERR    = 3'd7;

    localparam logic [31:0]       MAX_LEN_W = 32'(MAX_LEN);
    localparam logic [ADDR_W-1:0] OFS_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] OFS_TWO   = ADDR_W'(2);
    localparam logic [3:0]        DLY_LOAD  = 4'(LAT_EXTRA - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       len_q;
    logic [31:0]       k_q;
    logic [31:0]       acc_q;
    logic [31:0]       pend_data;
    logic              pend_err;
    logic [3:0]        dly_cnt;

    logic        addr_bad;
    logic        len_ok;
    logic [31:0] k_next;
    logic        stream_last;
    logic [63:0] rot_wide;
    logic [31:0] stream_word;
    logic        fin;
    logic [31:0] fin_data;
    logic        fin_err;

    assign addr_bad    = (logic_addr[1:0] != 2'b00) || (logic_addr[31:ADDR_W+2] != '0);
    assign len_ok      = (mem_rdata != 32'd0) && (mem_rdata <= MAX_LEN_W);
    assign k_next      = k_q + 32'd1;
    assign stream_last = (k_next == len_q);
    assign rot_wide    = {mem_rdata, mem_rdata} << k_q[4:0];
    assign stream_word = rot_wide[63:32];

    assign busy      = (state != S_IDLE);
    assign logic_ack = (state == S_ACK);

    always_comb begin
        mem_en   = 1'b0;
        mem_addr = '0;
        case (state)
            S_ISSUE_LEN: begin
                mem_en   = 1'b1;
                mem_addr = base_q;
            end
            S_CAPTURE_LEN: begin
                if (len_ok) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + OFS_ONE;
                end
            end
            S_STREAM: begin
                if (!stream_last) begin
                    mem_en   = 1'b1;
                    mem_addr = base_q + OFS_TWO + k_q[ADDR_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // Every path that produces a response funnels through fin.
    always_comb begin
        fin      = 1'b0;
        fin_data = 32'd0;
        fin_err  = 1'b0;
        case (state)
            S_ADDR_ERR: begin
                fin      = 1'b1;
                fin_data = 32'hFFFF_FFFE;
                fin_err  = 1'b1;
            end
            S_CAPTURE_LEN: begin
                if (mem_rdata > MAX_LEN_W) begin
                    fin      = 1'b1;
                    fin_data = 32'hFFFF_FFFF;
                    fin_err  = 1'b1;
                end else if (mem_rdata == 32'd0) begin
                    fin = 1'b1;
                end
            end
            S_STREAM: begin
                if (stream_last) begin
                    fin      = 1'b1;
                    fin_data = acc_q ^ stream_word;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            base_q     <= '0;
            len_q      <= 32'd0;
            k_q        <= 32'd0;
            acc_q      <= 32'd0;
            pend_data  <= 32'd0;
            pend_err   <= 1'b0;
            dly_cnt    <= 4'd0;
            logic_data <= 32'd0;
            err        <= 1'b0;
            req_count  <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (logic_req) begin
                        base_q    <= logic_addr[ADDR_W+1:2];
                        req_count <= req_count + 32'd1;
                        state     <= addr_bad ? S_ADDR_ERR : S_ISSUE_LEN;
                    end
                end
                S_ISSUE_LEN: state <= S_CAPTURE_LEN;
                S_CAPTURE_LEN: begin
                    len_q <= mem_rdata;
                    if (len_ok) begin
                        k_q   <= 32'd0;
                        acc_q <= 32'd0;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    acc_q <= acc_q ^ stream_word;
                    if (!stream_last) k_q <= k_next;
                end
                S_DELAY: begin
                    if (dly_cnt == 4'd0) begin
                        state      <= S_ACK;
                        logic_data <= pend_data;
                        err        <= pend_err;
                    end else begin
                        dly_cnt <= dly_cnt - 4'd1;
                    end
                end
                S_ACK: state <= S_WAIT_LOW;
                S_WAIT_LOW: begin
                    if (!logic_req) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (fin) begin
                if (LAT_EXTRA == 0) begin
                    state      <= S_ACK;
                    logic_data <= fin_data;
                    err        <= fin_err;
                end else begin
                    state     <= S_DELAY;
                    pend_data <= fin_data;
                    pend_err  <= fin_err;
                    dly_cnt   <= DLY_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_engine_responder.sv
// Bench for logic_engine_responder: two instances (LAT_EXTRA 0 and 3) share one
// request port and one certificate memory image; results come from a digest model.
module tb_logic_engine_responder;

    localparam int AW      = 8;
    localparam int MAXL    = 64;
    localparam int LAT [2] = '{0, 3};

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;

    logic        ack    [2];
    logic [31:0] data   [2];
    logic        en     [2];
    logic [7:0]  maddr  [2];
    logic [31:0] rdata  [2];
    logic        busy_o [2];
    logic        err_o  [2];
    logic [31:0] cnt    [2];

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (en[0]) rdata[0] <= mem[maddr[0]];
        if (en[1]) rdata[1] <= mem[maddr[1]];
    end

    logic_engine_responder #(.ADDR_W(AW), .MAX_LEN(MAXL), .LAT_EXTRA(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .logic_req(req), .logic_addr(addr),
        .logic_ack(ack[0]), .logic_data(data[0]), .mem_en(en[0]), .mem_addr(maddr[0]),
        .mem_rdata(rdata[0]), .busy(busy_o[0]), .err(err_o[0]), .req_count(cnt[0])
    );

    logic_engine_responder #(.ADDR_W(AW), .MAX_LEN(MAXL), .LAT_EXTRA(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .logic_req(req), .logic_addr(addr),
        .logic_ack(ack[1]), .logic_data(data[1]), .mem_en(en[1]), .mem_addr(maddr[1]),
        .mem_rdata(rdata[1]), .busy(busy_o[1]), .err(err_o[1]), .req_count(cnt[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_digest(input int base, input int len);
        logic [31:0] acc = 32'd0;
        for (int k = 0; k < len; k++) begin
            logic [31:0] w = mem[(base + 1 + k) % 256];
            int r = k % 32;
            acc ^= (r == 0) ? w : ((w << r) | (w >> (32 - r)));
        end
        return acc;
    endfunction

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_ack%0d", tag, d), 32'(ack[d]), 32'd0);
            check($sformatf("%s_data%0d", tag, d), data[d], 32'd0);
            check($sformatf("%s_err%0d", tag, d), 32'(err_o[d]), 32'd0);
            check($sformatf("%s_en%0d", tag, d), 32'(en[d]), 32'd0);
            check($sformatf("%s_maddr%0d", tag, d), 32'(maddr[d]), 32'd0);
            check($sformatf("%s_busy%0d", tag, d), 32'(busy_o[d]), 32'd0);
            check($sformatf("%s_cnt%0d", tag, d), cnt[d], 32'd0);
        end
    endtask

    // One full handshake; req is held for `hold` cycles after the later ack.
    task automatic run_req(input string tag, input logic [31:0] a, input int hold);
        int          e_lat, e_en;
        logic [31:0] e_data, e_err, L;
        int          lat [2];
        int          acks [2];
        int          ens [2];
        logic [31:0] g_data [2];
        logic [31:0] g_err [2];
        int          j;
        bit          done;

        if (a[1:0] != 2'b00 || (a >> (AW + 2)) != 0) begin
            e_lat = 1; e_en = 0; e_data = 32'hFFFF_FFFE; e_err = 1;
        end else begin
            int base = int'((a >> 2) % 256);
            L = mem[base];
            if (L > MAXL) begin
                e_lat = 2; e_en = 1; e_data = 32'hFFFF_FFFF; e_err = 1;
            end else if (L == 0) begin
                e_lat = 2; e_en = 1; e_data = 32'd0; e_err = 0;
            end else begin
                e_lat = 2 + int'(L); e_en = 1 + int'(L);
                e_data = ref_digest(base, int'(L)); e_err = 0;
            end
        end

        @(negedge clk);
        req  = 1'b1;
        addr = a;
        exp_cnt++;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            lat[d] = -1; acks[d] = 0; ens[d] = 0; g_data[d] = 32'hDEAD_BEEF; g_err[d] = 32'hDEAD_BEEF;
        end
        j = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            addr = $urandom;
            for (int d = 0; d < 2; d++) begin
                if (en[d]) ens[d]++;
                if (ack[d]) begin
                    acks[d]++;
                    if (lat[d] < 0) begin
                        lat[d] = j;
                        g_data[d] = data[d];
                        g_err[d] = 32'(err_o[d]);
                    end
                end
            end
            j++;
            if (lat[0] >= 0 && lat[1] >= 0 && j > lat[1] + hold) done = 1;
            if (j > 600) done = 1;
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_lat%0d", tag, d), 32'(lat[d]), 32'(e_lat + LAT[d]));
            check($sformatf("%s_acks%0d", tag, d), 32'(acks[d]), 32'd1);
            check($sformatf("%s_data%0d", tag, d), g_data[d], e_data);
            check($sformatf("%s_err%0d", tag, d), g_err[d], e_err);
            check($sformatf("%s_en%0d", tag, d), 32'(ens[d]), 32'(e_en));
            check($sformatf("%s_cnt%0d", tag, d), cnt[d], 32'(exp_cnt));
            check($sformatf("%s_hold%0d", tag, d), data[d], e_data);
        end
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++)
            check($sformatf("%s_idle%0d", tag, d), 32'(busy_o[d]), 32'd0);
    endtask

    initial begin
        int acks_seen;
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        rdata[0] = 32'd0;
        rdata[1] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        mem[8'h10] = 32'd3;
        mem[8'h11] = 32'd1;
        mem[8'h12] = 32'd1;
        mem[8'h13] = 32'd1;
        run_req("basic", 32'h40, 20);
        run_req("rearm", 32'h40, 2);

        mem[8'h20] = 32'd0;
        run_req("len0", 32'h80, 2);
        mem[8'h20] = 32'd65;
        run_req("len_over", 32'h80, 2);

        run_req("misalign", 32'h41, 2);
        run_req("high_addr", 32'h400, 2);

        mem[8'hFE] = 32'd2;
        mem[8'hFF] = 32'h1;
        mem[8'h00] = 32'h8000_0000;
        run_req("wrap", 32'h3F8, 2);

        for (int t = 0; t < 30; t++) begin
            int kind = int'($urandom_range(0, 9));
            int base = int'($urandom_range(0, 255));
            logic [31:0] a;
            if (kind == 0) begin
                a = (32'(base) << 2) | 32'($urandom_range(1, 3));
            end else if (kind == 1) begin
                a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            end else begin
                if (kind == 2) mem[base] = 32'd0;
                else if (kind == 3) mem[base] = 32'(MAXL + 1) + 32'($urandom_range(0, 2000));
                else mem[base] = 32'($urandom_range(1, MAXL));
                if (kind >= 4)
                    for (int k = 0; k < int'(mem[base]); k++) mem[(base + 1 + k) % 256] = $urandom;
                a = 32'(base) << 2;
            end
            run_req($sformatf("rnd%0d", t), a, 2);
        end

        // Reset while streaming a 10-word descriptor abandons it without an ack.
        mem[8'h30] = 32'd10;
        for (int k = 0; k < 10; k++) mem[8'h31 + k] = $urandom;
        @(negedge clk);
        req  = 1'b1;
        addr = 32'hC0;
        @(posedge clk);
        acks_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack[0] || ack[1]) acks_seen++;
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (ack[0] || ack[1]) acks_seen++;
        check("midrst_noack", 32'(acks_seen), 32'd0);
        check_idle_outputs("midrst");
        exp_cnt = 0;
        req   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_req("after_rst", 32'hC0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
